// File: rtl/x_mem_responder_pkg.sv
// -----------------------------------------------------------------------------
// x_mem_responder_pkg
// Shared types and constants for the x_mem_responder memory target.
//   sm_t             : responder state machine encoding (IDLE, WAIT, RESP)
//   REG_GPIO_IDX     : register index (i_addr[3:2]) of the GPIO output register
//   REG_CYCLE_IDX    : register index (i_addr[3:2]) of the read-only cycle counter
//   REGION_BIT       : address bit selecting RAM (0) or register space (1)
//   rot_right_bytes  : rotate a 32-bit word right by whole bytes
// -----------------------------------------------------------------------------
package x_mem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } sm_t;

    localparam logic [1:0] REG_GPIO_IDX  = 2'd0;
    localparam logic [1:0] REG_CYCLE_IDX = 2'd1;
    localparam int         REGION_BIT    = 31;

    // Moves the addressed byte lane down to bits [7:0] so the initiator can
    // sign/zero extend byte and halfword loads from the low lane.
    function automatic logic [31:0] rot_right_bytes(input logic [31:0] word,
                                                    input logic [1:0]  lane);
        logic [31:0] rot;
        case (lane)
            2'd0:    rot = word;
            2'd1:    rot = {word[7:0],  word[31:8]};
            2'd2:    rot = {word[15:0], word[31:16]};
            default: rot = {word[23:0], word[31:24]};
        endcase
        return rot;
    endfunction

endpackage

// File: rtl/x_mem_responder_ram.sv
// -----------------------------------------------------------------------------
// x_mem_responder_ram
// Word-organised synchronous single-port RAM. One read or one write per
// enabled clock edge; the read result is registered and held until the next
// enabled read (writes leave the read register untouched). Contents are not
// reset.
// Ports:
//   i_clk    : clock
//   i_en     : access enable for this edge
//   i_we     : 1 = write i_wdata, 0 = read into o_rdata
//   i_idx    : word index
//   i_wdata  : write data
//   o_rdata  : registered read data
// -----------------------------------------------------------------------------
module x_mem_responder_ram #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  i_clk,
    input  logic                  i_en,
    input  logic                  i_we,
    input  logic [DEPTH_LOG2-1:0] i_idx,
    input  logic [31:0]           i_wdata,
    output logic [31:0]           o_rdata
);

    logic [31:0] r_mem [0:(1<<DEPTH_LOG2)-1];
    logic [31:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_en) begin
            if (i_we) begin
                r_mem[i_idx] <= i_wdata;
            end else begin
                r_rdata <= r_mem[i_idx];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/x_mem_responder.sv
// -----------------------------------------------------------------------------
// x_mem_responder
// Memory/peripheral target on the single-channel valid/accept bus of the rv32i
// core. Serves fetches, loads and stores from a word RAM and a small register
// region (GPIO output register, optional free-running cycle counter).
//
// Build option: define X_MEM_RESPONDER_CYCLE_CNT_EN to include the 32-bit cycle
// counter; otherwise the CYCLE register reads 0 and no counter flops exist.
//
// Parameters:
//   DEPTH_LOG2   : log2 of RAM depth in 32-bit words
//   WAIT_CYCLES  : extra wait states per transaction (0..15)
// Ports:
//   i_clk     : clock
//   i_nrst    : asynchronous active-low reset
//   i_valid   : request, held by the initiator until accepted
//   i_rnw     : 1 = read, 0 = write
//   i_addr    : byte address (bit 31 selects register space)
//   i_data    : write data (full word is written)
//   o_accept  : one-cycle completion pulse, o_data valid for reads
//   o_data    : read data, holds its value outside the accept cycle
//   o_gpio    : GPIO output register
// -----------------------------------------------------------------------------
module x_mem_responder
    import x_mem_responder_pkg::*;
#(
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        i_clk,
    input  logic        i_nrst,
    input  logic        i_valid,
    input  logic        i_rnw,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_data,
    output logic        o_accept,
    output logic [31:0] o_data,
    output logic [31:0] o_gpio
);

    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    // State machine
    sm_t                   r_state;
    sm_t                   w_state_next;
    logic [3:0]            r_cnt;
    logic [3:0]            w_cnt_next;
    logic                  w_capture;
    logic                  w_go_resp;

    // Captured request, kept as the decoded fields actually needed
    logic                  r_rnw;
    logic                  r_is_reg;
    logic [1:0]            r_reg_idx;
    logic [DEPTH_LOG2-1:0] r_word_idx;
    logic [1:0]            r_lane;
    logic [31:0]           r_wdata;

    // Access performed on the edge into RESP
    logic                  w_acc_rnw;
    logic                  w_acc_is_reg;
    logic [1:0]            w_acc_reg_idx;
    logic [DEPTH_LOG2-1:0] w_acc_idx;
    logic [1:0]            w_acc_lane;
    logic [31:0]           w_acc_data;

    logic                  w_ram_en;
    logic [31:0]           w_ram_rdata;
    logic [31:0]           w_reg_rd;
    logic [31:0]           w_cycle_val;

    // Read-result registers; o_data is selected from these
    logic                  r_rd_ram;
    logic [1:0]            r_rd_lane;
    logic [31:0]           r_reg_rdata;
    logic [31:0]           r_gpio;

    // Address bits between the RAM index and the region bit are ignored.
    logic                  w_unused;
    assign w_unused = ^i_addr[30:2];

    // -------------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_capture    = 1'b0;
        w_go_resp    = 1'b0;
        o_accept     = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_valid) begin
                    w_capture = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        w_state_next = RESP;
                        w_go_resp    = 1'b1;
                    end else begin
                        w_state_next = WAIT;
                        w_cnt_next   = WAIT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_next = RESP;
                    w_go_resp    = 1'b1;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            RESP: begin
                o_accept     = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Request capture
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_rnw      <= 1'b1;
            r_is_reg   <= 1'b0;
            r_reg_idx  <= 2'd0;
            r_word_idx <= '0;
            r_lane     <= 2'd0;
            r_wdata    <= 32'd0;
        end else if (w_capture) begin
            r_rnw      <= i_rnw;
            r_is_reg   <= i_addr[REGION_BIT];
            r_reg_idx  <= i_addr[3:2];
            r_word_idx <= i_addr[DEPTH_LOG2+1:2];
            r_lane     <= i_addr[1:0];
            r_wdata    <= i_data;
        end
    end

    // With zero wait states the access happens on the capture edge itself, so
    // it must come straight from the bus instead of the request registers.
    always_comb begin
        if (r_state == IDLE) begin
            w_acc_rnw     = i_rnw;
            w_acc_is_reg  = i_addr[REGION_BIT];
            w_acc_reg_idx = i_addr[3:2];
            w_acc_idx     = i_addr[DEPTH_LOG2+1:2];
            w_acc_lane    = i_addr[1:0];
            w_acc_data    = i_data;
        end else begin
            w_acc_rnw     = r_rnw;
            w_acc_is_reg  = r_is_reg;
            w_acc_reg_idx = r_reg_idx;
            w_acc_idx     = r_word_idx;
            w_acc_lane    = r_lane;
            w_acc_data    = r_wdata;
        end
    end

    // -------------------------------------------------------------------------
    // RAM
    // -------------------------------------------------------------------------
    // Gating with i_nrst keeps a held request from touching the RAM while the
    // rest of the design is being reset.
    assign w_ram_en = w_go_resp & ~w_acc_is_reg & i_nrst;

    x_mem_responder_ram #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .i_clk   (i_clk),
        .i_en    (w_ram_en),
        .i_we    (~w_acc_rnw),
        .i_idx   (w_acc_idx),
        .i_wdata (w_acc_data),
        .o_rdata (w_ram_rdata)
    );

    // -------------------------------------------------------------------------
    // Cycle counter
    // -------------------------------------------------------------------------
`ifdef X_MEM_RESPONDER_CYCLE_CNT_EN
    logic [31:0] r_cycle;

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_cycle <= 32'd0;
        end else begin
            r_cycle <= r_cycle + 32'd1;
        end
    end

    assign w_cycle_val = r_cycle;
`else
    assign w_cycle_val = 32'd0;
`endif

    // -------------------------------------------------------------------------
    // Register region and read data
    // -------------------------------------------------------------------------
    always_comb begin
        w_reg_rd = 32'd0;
        case (w_acc_reg_idx)
            REG_GPIO_IDX:  w_reg_rd = r_gpio;
            REG_CYCLE_IDX: w_reg_rd = w_cycle_val;
            default:       w_reg_rd = 32'd0;
        endcase
    end

    // Reads only update the source select and lane, so o_data keeps showing the
    // last read result across writes and idle cycles. The RAM read register is
    // only reloaded by RAM reads, which makes it hold too.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_rd_ram    <= 1'b0;
            r_rd_lane   <= 2'd0;
            r_reg_rdata <= 32'd0;
            r_gpio      <= 32'd0;
        end else if (w_go_resp) begin
            if (w_acc_rnw) begin
                r_rd_ram  <= ~w_acc_is_reg;
                r_rd_lane <= w_acc_lane;
                if (w_acc_is_reg) begin
                    r_reg_rdata <= w_reg_rd;
                end
            end else if (w_acc_is_reg && (w_acc_reg_idx == REG_GPIO_IDX)) begin
                r_gpio <= w_acc_data;
            end
        end
    end

    assign o_data = r_rd_ram ? rot_right_bytes(w_ram_rdata, r_rd_lane) : r_reg_rdata;
    assign o_gpio = r_gpio;

endmodule
